// File: rtl/cam_precip_filter_pkg.sv
// Shared types, hash/LFSR constants and colour helpers for the precipitation overlay filter.
package cam_precip_filter_pkg;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'd0,
        MODE_RAIN   = 2'd1,
        MODE_SNOW   = 2'd2,
        MODE_STORM  = 2'd3
    } precip_mode_e;

    localparam int unsigned HashMulX     = 73;
    localparam int unsigned HashMulY     = 97;
    localparam int unsigned SplashMulX   = 127;
    localparam int unsigned SplashMulT   = 31;
    localparam int unsigned SplashThresh = 50;

    // x^16 + x^14 + x^13 + x^11 + 1 -> register bits 15, 13, 12, 10
    localparam logic [15:0] LfsrSeed = 16'hACE1;
    localparam logic [15:0] LfsrTaps = 16'hB400;

    localparam logic [3:0] RainDropR = 4'hC;
    localparam logic [3:0] RainDropG = 4'hD;
    localparam logic [3:0] RainDropB = 4'hF;
    localparam logic [3:0] SnowDrop  = 4'hF;
    localparam logic [3:0] TrailAddR = 4'h4;
    localparam logic [3:0] TrailAddG = 4'h5;
    localparam logic [3:0] TrailAddB = 4'h7;
    localparam logic [3:0] SplashR   = 4'h8;
    localparam logic [3:0] SplashG   = 4'hA;
    localparam logic [3:0] SplashB   = 4'hE;

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], ^(l & LfsrTaps)};
    endfunction

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b,
                                            input logic [15:0] max_v);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, max_v}) ? max_v : s[15:0];
    endfunction

endpackage

// File: rtl/cam_precip_filter_frame_ctrl.sv
// Frame-rate state: v_sync edge, animation timer with speed divider, LFSR, latched mode
// and the lightning flash counter.
module cam_precip_filter_frame_ctrl
    import cam_precip_filter_pkg::*;
#(
    parameter int unsigned SPEED_DIV    = 3,
    parameter int unsigned FLASH_FRAMES = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         v_sync_i,
    input  precip_mode_e mode_i,
    output precip_mode_e mode_q_o,
    output logic [9:0]   timer_o,
    output logic         flash_active_o
);

    localparam int unsigned SpdW   = (SPEED_DIV > 1) ? $clog2(SPEED_DIV) : 1;
    localparam int unsigned FlashW = (FLASH_FRAMES > 0) ? $clog2(FLASH_FRAMES + 1) : 1;

    logic              v_sync_q;
    logic              fe;
    logic [SpdW-1:0]   spd_q, spd_d;
    logic [9:0]        timer_q, timer_d;
    logic [15:0]       lfsr_q, lfsr_d;
    precip_mode_e      mode_q, mode_d;
    logic [FlashW-1:0] flash_q, flash_d;

    assign fe = v_sync_i & ~v_sync_q;

    always_comb begin
        spd_d   = spd_q;
        timer_d = timer_q;
        lfsr_d  = lfsr_q;
        mode_d  = mode_q;
        flash_d = flash_q;
        if (fe) begin
            mode_d = mode_i;
            lfsr_d = lfsr_next(lfsr_q);
            if (spd_q == SpdW'(SPEED_DIV - 1)) begin
                spd_d   = '0;
                timer_d = timer_q + 10'd1;
            end else begin
                spd_d = spd_q + SpdW'(1);
            end
            // Flash triggers only once storm was already latched for the ending frame.
            if (mode_i != MODE_STORM) begin
                flash_d = '0;
            end else if (mode_q == MODE_STORM && flash_q == '0 && lfsr_q[5:0] == 6'd0) begin
                flash_d = FlashW'(FLASH_FRAMES);
            end else if (flash_q != '0) begin
                flash_d = flash_q - FlashW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v_sync_q <= 1'b0;
            spd_q    <= '0;
            timer_q  <= '0;
            lfsr_q   <= LfsrSeed;
            mode_q   <= MODE_BYPASS;
            flash_q  <= '0;
        end else begin
            v_sync_q <= v_sync_i;
            spd_q    <= spd_d;
            timer_q  <= timer_d;
            lfsr_q   <= lfsr_d;
            mode_q   <= mode_d;
            flash_q  <= flash_d;
        end
    end

    assign mode_q_o       = mode_q;
    assign timer_o        = timer_q;
    assign flash_active_o = (flash_q != '0);

endmodule

// File: rtl/cam_precip_filter.sv
// Precipitation overlay between frame-buffer read and VGA mux: stage 1 registers the pixel
// and hash hits, stage 2 registers the composited colour.
module cam_precip_filter
    import cam_precip_filter_pkg::*;
#(
    parameter int unsigned COLOR_W      = 4,
    parameter int unsigned X_W          = 10,
    parameter int unsigned Y_W          = 10,
    parameter int unsigned SPEED_DIV    = 3,
    parameter int unsigned TRAIL_LEN    = 4,
    parameter int unsigned DENSITY_W    = 11,
    parameter int unsigned SPLASH_ROWS  = 10,
    parameter int unsigned V_RES        = 480,
    parameter int unsigned FLASH_FRAMES = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               v_sync,
    input  logic               DE,
    input  logic [X_W-1:0]     x,
    input  logic [Y_W-1:0]     y,
    input  logic [1:0]         mode,
    input  logic [COLOR_W-1:0] cam_r,
    input  logic [COLOR_W-1:0] cam_g,
    input  logic [COLOR_W-1:0] cam_b,
    output logic               out_de,
    output logic [COLOR_W-1:0] out_r,
    output logic [COLOR_W-1:0] out_g,
    output logic [COLOR_W-1:0] out_b,
    output logic               flash_active
);

    localparam logic [15:0]        DensMask = 16'((32'd1 << DENSITY_W) - 32'd1);
    localparam logic [COLOR_W-1:0] ColorMax = '1;
    localparam logic [COLOR_W-1:0] HalfMax  = ColorMax >> 1;

    function automatic logic hash_hit(input logic [15:0] xo, input logic [15:0] yo);
        logic [15:0] h;
        h = (xo * 16'(HashMulX) + yo * 16'(HashMulY)) ^ {4'b0, xo[3:0], 8'b0};
        return (h & DensMask) == 16'd0;
    endfunction

    // 4-bit palette entry widened with its MSB replicated into the new LSBs.
    function automatic logic [COLOR_W-1:0] scale4(input logic [3:0] c);
        logic [COLOR_W-1:0] r;
        r = {COLOR_W{c[3]}};
        r[COLOR_W-1 -: 4] = c;
        return r;
    endfunction

    function automatic logic [COLOR_W-1:0] sat(input logic [COLOR_W-1:0] a,
                                               input logic [COLOR_W-1:0] b);
        return COLOR_W'(sat_add(16'(a), 16'(b), 16'(ColorMax)));
    endfunction

    function automatic logic [COLOR_W-1:0] dec_floor(input logic [COLOR_W-1:0] c);
        return (c == '0) ? '0 : c - COLOR_W'(1);
    endfunction

    precip_mode_e mode_q;
    logic [9:0]   timer;

    cam_precip_filter_frame_ctrl #(
        .SPEED_DIV   (SPEED_DIV),
        .FLASH_FRAMES(FLASH_FRAMES)
    ) u_ctrl (
        .clk_i         (clk),
        .rst_ni        (reset_n),
        .v_sync_i      (v_sync),
        .mode_i        (precip_mode_e'(mode)),
        .mode_q_o      (mode_q),
        .timer_o       (timer),
        .flash_active_o(flash_active)
    );

    logic [15:0] xd, yd, t16, rain_yo;
    logic [8:0]  splash_mix;
    logic        drop_d, trail_d, splash_d, rain_like;

    always_comb begin
        xd         = 16'(x) >> 1;
        yd         = 16'(y) >> 1;
        t16        = 16'(timer);
        rain_yo    = yd + (t16 << 2);
        rain_like  = (mode_q == MODE_RAIN) || (mode_q == MODE_STORM);
        splash_mix = (9'(x) * 9'(SplashMulX)) ^ (9'(timer) * 9'(SplashMulT));
        drop_d     = 1'b0;
        trail_d    = 1'b0;
        splash_d   = 1'b0;
        if (rain_like) begin
            drop_d = hash_hit(xd, rain_yo);
            for (int unsigned k = 1; k <= TRAIL_LEN; k++) begin
                trail_d = trail_d | hash_hit(xd, rain_yo - 16'(k));
            end
            splash_d = (32'(y) >= (V_RES - SPLASH_ROWS)) && (32'(y) < V_RES) &&
                       (splash_mix < 9'(SplashThresh));
        end else if (mode_q == MODE_SNOW) begin
            drop_d = hash_hit(xd + 16'(timer[4]), yd + t16);
        end
    end

    logic               s1_de_q, s1_flash_q, s1_drop_q, s1_trail_q, s1_splash_q;
    logic [COLOR_W-1:0] s1_r_q, s1_g_q, s1_b_q;
    precip_mode_e       s1_mode_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_de_q     <= 1'b0;
            s1_r_q      <= '0;
            s1_g_q      <= '0;
            s1_b_q      <= '0;
            s1_mode_q   <= MODE_BYPASS;
            s1_flash_q  <= 1'b0;
            s1_drop_q   <= 1'b0;
            s1_trail_q  <= 1'b0;
            s1_splash_q <= 1'b0;
        end else begin
            s1_de_q     <= DE;
            s1_r_q      <= cam_r;
            s1_g_q      <= cam_g;
            s1_b_q      <= cam_b;
            s1_mode_q   <= mode_q;
            s1_flash_q  <= flash_active;
            s1_drop_q   <= drop_d;
            s1_trail_q  <= trail_d;
            s1_splash_q <= splash_d;
        end
    end

    logic [COLOR_W-1:0] r_d, g_d, b_d;
    logic               is_snow;

    always_comb begin
        r_d     = '0;
        g_d     = '0;
        b_d     = '0;
        is_snow = (s1_mode_q == MODE_SNOW);
        if (s1_de_q) begin
            if (s1_mode_q == MODE_BYPASS) begin
                r_d = s1_r_q;
                g_d = s1_g_q;
                b_d = s1_b_q;
            end else if (s1_flash_q) begin
                r_d = sat(s1_r_q, HalfMax);
                g_d = sat(s1_g_q, HalfMax);
                b_d = sat(s1_b_q, HalfMax);
            end else if (s1_drop_q) begin
                r_d = is_snow ? scale4(SnowDrop) : scale4(RainDropR);
                g_d = is_snow ? scale4(SnowDrop) : scale4(RainDropG);
                b_d = is_snow ? scale4(SnowDrop) : scale4(RainDropB);
            end else if (s1_trail_q) begin
                r_d = sat(s1_r_q >> 1, scale4(TrailAddR));
                g_d = sat(s1_g_q >> 1, scale4(TrailAddG));
                b_d = sat(s1_b_q >> 1, scale4(TrailAddB));
            end else if (s1_splash_q) begin
                r_d = scale4(SplashR);
                g_d = scale4(SplashG);
                b_d = scale4(SplashB);
            end else if (is_snow) begin
                r_d = s1_r_q;
                g_d = s1_g_q;
                b_d = s1_b_q;
            end else begin
                // Rain darkens red/green slightly to give a cool cast.
                r_d = dec_floor(s1_r_q);
                g_d = dec_floor(s1_g_q);
                b_d = s1_b_q;
            end
        end
    end

    logic               out_de_q;
    logic [COLOR_W-1:0] out_r_q, out_g_q, out_b_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_de_q <= 1'b0;
            out_r_q  <= '0;
            out_g_q  <= '0;
            out_b_q  <= '0;
        end else begin
            out_de_q <= s1_de_q;
            out_r_q  <= r_d;
            out_g_q  <= g_d;
            out_b_q  <= b_d;
        end
    end

    assign out_de = out_de_q;
    assign out_r  = out_r_q;
    assign out_g  = out_g_q;
    assign out_b  = out_b_q;

endmodule

// File: tb/tb_cam_precip_filter.sv
// Directed bench for cam_precip_filter: bypass/latency, rain/snow hits, mode latching,
// storm flash timing and the animation timer divider.
module tb_cam_precip_filter;

    logic       clk;
    logic       reset_n;
    logic       v_sync;
    logic       de;
    logic [9:0] x;
    logic [9:0] y;
    logic [1:0] mode;
    logic [3:0] cam_r, cam_g, cam_b;
    logic       out_de;
    logic [3:0] out_r, out_g, out_b;
    logic       flash_active;

    int errors = 0;
    int checks = 0;

    // Frame-rate reference state
    logic [15:0] lfsr_m;
    logic [1:0]  mq_m;
    int          cnt_m, sp_m, tm_m;
    logic        found;

    cam_precip_filter dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .v_sync      (v_sync),
        .DE          (de),
        .x           (x),
        .y           (y),
        .mode        (mode),
        .cam_r       (cam_r),
        .cam_g       (cam_g),
        .cam_b       (cam_b),
        .out_de      (out_de),
        .out_r       (out_r),
        .out_g       (out_g),
        .out_b       (out_b),
        .flash_active(flash_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_pix(input string tag, input logic e_de, input logic [3:0] er,
                           input logic [3:0] eg, input logic [3:0] eb);
        checks++;
        assert ({out_de, out_r, out_g, out_b} === {e_de, er, eg, eb}) else begin
            errors++;
            $error("FAIL %s: got de=%0b rgb=%h,%h,%h expected de=%0b rgb=%h,%h,%h",
                   tag, out_de, out_r, out_g, out_b, e_de, er, eg, eb);
        end
    endtask

    task automatic chk_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        lfsr_m = 16'hACE1;
        mq_m   = 2'd0;
        cnt_m  = 0;
        sp_m   = 0;
        tm_m   = 0;
    endtask

    task automatic pix(input logic de_v, input logic [9:0] xv, input logic [9:0] yv,
                       input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
        @(negedge clk);
        de = de_v; x = xv; y = yv; cam_r = r; cam_g = g; cam_b = b;
        @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse();
        @(negedge clk);
        de     = 1'b0;
        v_sync = 1'b1;
        @(negedge clk);
        v_sync = 1'b0;
        @(negedge clk);
        if (mode != 2'd3) cnt_m = 0;
        else if (mq_m == 2'd3 && cnt_m == 0 && lfsr_m[5:0] == 6'd0) cnt_m = 2;
        else if (cnt_m != 0) cnt_m = cnt_m - 1;
        mq_m   = mode;
        lfsr_m = {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
        if (sp_m == 2) begin
            sp_m = 0;
            tm_m = (tm_m == 1023) ? 0 : tm_m + 1;
        end else begin
            sp_m = sp_m + 1;
        end
    endtask

    task automatic seek_trigger(input string tag);
        found = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            if (lfsr_m[5:0] == 6'd0 && cnt_m == 0) begin
                found = 1'b1;
                break;
            end
            pulse();
        end
        chk_val(tag, 16'(found), 16'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        v_sync  = 1'b0;
        de      = 1'b0;
        x       = '0;
        y       = '0;
        mode    = 2'd1;
        cam_r   = '0;
        cam_g   = '0;
        cam_b   = '0;
        model_reset();
        #23;
        chk_pix("reset_out", 1'b0, 4'h0, 4'h0, 4'h0);
        chk_val("reset_flash", 16'(flash_active), 16'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Mode input is rain but nothing latched yet -> bypass
        pix(1'b1, 10'd20, 10'd100, 4'h3, 4'h7, 4'h9);
        chk_pix("post_reset_bypass", 1'b1, 4'h3, 4'h7, 4'h9);
        pix(1'b0, 10'd20, 10'd100, 4'h3, 4'h7, 4'h9);
        chk_pix("bypass_de_low", 1'b0, 4'h0, 4'h0, 4'h0);

        @(negedge clk);
        de = 1'b1;
        @(posedge clk);
        #1;
        chk_pix("lat_1clk", 1'b0, 4'h0, 4'h0, 4'h0);
        @(posedge clk);
        #1;
        chk_pix("lat_2clk", 1'b1, 4'h3, 4'h7, 4'h9);

        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk_pix("reset_async", 1'b0, 4'h0, 4'h0, 4'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Rain, timer 0
        mode = 2'd1;
        pulse();
        pix(1'b1, 10'd0, 10'd0, 4'h0, 4'h0, 4'h0);
        chk_pix("rain_drop", 1'b1, 4'hC, 4'hD, 4'hF);
        pix(1'b1, 10'd0, 10'd2, 4'hF, 4'hF, 4'hF);
        chk_pix("rain_trail", 1'b1, 4'hB, 4'hC, 4'hE);
        pix(1'b1, 10'd20, 10'd100, 4'h0, 4'h5, 4'h5);
        chk_pix("rain_default", 1'b1, 4'h0, 4'h4, 4'h5);
        pix(1'b1, 10'd0, 10'd475, 4'h1, 4'h1, 4'h1);
        chk_pix("rain_splash", 1'b1, 4'h8, 4'hA, 4'hE);
        pix(1'b0, 10'd0, 10'd0, 4'h5, 4'h5, 4'h5);
        chk_pix("rain_de_low", 1'b0, 4'h0, 4'h0, 4'h0);

        // Snow requested mid-frame takes effect at the next frame edge
        mode = 2'd2;
        pix(1'b1, 10'd0, 10'd0, 4'h1, 4'h2, 4'h3);
        chk_pix("latch_hold", 1'b1, 4'hC, 4'hD, 4'hF);
        pulse();
        pix(1'b1, 10'd0, 10'd0, 4'h1, 4'h2, 4'h3);
        chk_pix("snow_drop", 1'b1, 4'hF, 4'hF, 4'hF);
        pix(1'b1, 10'd0, 10'd2, 4'h2, 4'h4, 4'h6);
        chk_pix("snow_no_trail", 1'b1, 4'h2, 4'h4, 4'h6);

        // Storm: first edge only latches the mode
        mode = 2'd3;
        pulse();
        chk_val("storm_no_flash_yet", 16'(flash_active), 16'd0);
        seek_trigger("lfsr_bound1");
        pulse();
        chk_val("flash_on", 16'(flash_active), 16'd1);
        pix(1'b1, 10'd20, 10'd100, 4'hA, 4'h2, 4'h0);
        chk_pix("flash_pix", 1'b1, 4'hF, 4'h9, 4'h7);
        pulse();
        chk_val("flash_frame2", 16'(flash_active), 16'd1);
        pulse();
        chk_val("flash_expire", 16'(flash_active), 16'd0);
        seek_trigger("lfsr_bound2");
        pulse();
        chk_val("flash_on2", 16'(flash_active), 16'd1);
        mode = 2'd1;
        pulse();
        chk_val("flash_clear", 16'(flash_active), 16'd0);

        // Timer divider and wrap
        do_reset();
        mode = 2'd1;
        for (int i = 0; i < 7; i++) pulse();
        chk_val("timer_7", 16'(dut.u_ctrl.timer_q), 16'd2);
        chk_val("spd_7", 16'(dut.u_ctrl.spd_q), 16'd1);
        while (!(tm_m == 1023 && sp_m == 0)) pulse();
        chk_val("timer_max", 16'(dut.u_ctrl.timer_q), 16'd1023);
        for (int i = 0; i < 3; i++) pulse();
        chk_val("timer_wrap", 16'(dut.u_ctrl.timer_q), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
